// File: rtl/multiple_bcd.sv
`default_nettype none
// ============================================================================
// Module      : multiple_bcd
// Description : Four-digit cascaded BCD counter (0000..9999, wraps) with
//               tick prescaler, forming the stopwatch time base.
// Revision    : 1.0 - initial release
// ============================================================================
module multiple_bcd #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [3:0]    stage_en;
  logic [15:0]   digits;

  assign tick = en && (prescaler == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (en) begin
      if (tick) prescaler <= '0;
      else      prescaler <= prescaler + 1'b1;
    end
  end

  assign stage_en[0] = tick;

  // Each stage advances on its ripple enable; values >= 9 roll to 0 and carry,
  // so out-of-range digits self-heal on their next increment.
  for (genvar i = 0; i < 4; i++) begin : g_stage
    logic [3:0] q;
    logic       at_max;

    assign at_max = (q >= 4'd9);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q <= 4'd0;
      end else if (stage_en[i]) begin
        q <= at_max ? 4'd0 : q + 4'd1;
      end
    end

    assign digits[4*i +: 4] = q;

    if (i < 3) begin : g_carry
      assign stage_en[i+1] = stage_en[i] & at_max;
    end
  end

  assign d1 = digits[3:0];
  assign d2 = digits[7:4];
  assign d3 = digits[11:8];
  assign d4 = digits[15:12];

endmodule
`default_nettype wire

// File: tb/tb_multiple_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiple_bcd
// Description : Directed self-checking bench for multiple_bcd (PRESCALE 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiple_bcd;

  logic       clk = 1'b0;
  logic       reset_a = 1'b0, en_a = 1'b0;
  logic       reset_b = 1'b0, en_b = 1'b0;
  logic [3:0] a1, a2, a3, a4;
  logic [3:0] b1, b2, b3, b4;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  multiple_bcd #(.PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset_a), .en(en_a),
    .d1(a1), .d2(a2), .d3(a3), .d4(a4)
  );

  multiple_bcd #(.PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b),
    .d1(b1), .d2(b2), .d3(b3), .d4(b4)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous clear, before any clock edge
    #2;
    reset_a = 1'b1;
    reset_b = 1'b1;
    #1;
    check("reset_async_a", {a4, a3, a2, a1}, 16'h0000);
    check("reset_async_b", {b4, b3, b2, b1}, 16'h0000);
    edges(2);
    check("reset_hold", {a4, a3, a2, a1}, 16'h0000);

    reset_a = 1'b0;
    en_a    = 1'b1;
    edges(3);
    check("count_3", {a4, a3, a2, a1}, 16'h0003);
    edges(6);
    check("count_9", {a4, a3, a2, a1}, 16'h0009);
    edges(1);
    check("carry_10", {a4, a3, a2, a1}, 16'h0010);
    edges(989);
    check("count_999", {a4, a3, a2, a1}, 16'h0999);
    edges(1);
    check("ripple_1000", {a4, a3, a2, a1}, 16'h1000);
    edges(8999);
    check("count_9999", {a4, a3, a2, a1}, 16'h9999);
    edges(1);
    check("wrap_0000", {a4, a3, a2, a1}, 16'h0000);

    // Full wrap from reset, then hold
    reset_a = 1'b1;
    #2;
    reset_a = 1'b0;
    edges(10003);
    check("full_wrap_3", {a4, a3, a2, a1}, 16'h0003);
    en_a = 1'b0;
    edges(5);
    check("hold_en0", {a4, a3, a2, a1}, 16'h0003);

    // Mid-count reset between edges
    reset_a = 1'b1;
    #2;
    reset_a = 1'b0;
    en_a    = 1'b1;
    edges(427);
    check("count_427", {a4, a3, a2, a1}, 16'h0427);
    #3;
    reset_a = 1'b1;
    #1;
    check("mid_reset", {a4, a3, a2, a1}, 16'h0000);
    edges(3);
    check("reset_with_en", {a4, a3, a2, a1}, 16'h0000);
    reset_a = 1'b0;
    edges(1);
    check("resume_1", {a4, a3, a2, a1}, 16'h0001);

    // PRESCALE=4 instance: tick every 4th enabled edge, prescaler holds when en=0
    reset_b = 1'b0;
    en_b    = 1'b1;
    edges(3);
    check("pre4_3edges", {b4, b3, b2, b1}, 16'h0000);
    edges(1);
    check("pre4_4edges", {b4, b3, b2, b1}, 16'h0001);
    edges(1);
    en_b = 1'b0;
    edges(3);
    check("pre4_hold", {b4, b3, b2, b1}, 16'h0001);
    en_b = 1'b1;
    edges(2);
    check("pre4_7edges", {b4, b3, b2, b1}, 16'h0001);
    edges(1);
    check("pre4_8edges", {b4, b3, b2, b1}, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
